ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer for the 32x32 single-port data RAM. That RAM has a combinational read, writes on the negedge of clock, and is gated by chip_select.
- Lets two masters share the RAM through a req/ack handshake: port 0 is the CPU datapath, port 1 is the loader/DMA.
- Every RAM control signal is driven from registers, so the RAM sees stable inputs across the negedge write.
- Sits between the masters and the RAM instance.

Parameters:
- ADDR_WIDTH, 5, RAM address width.
- DATA_WIDTH, 32, RAM word width.
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins a tie.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 access request; held high until ack0.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  ADDR_WIDTH  port 0 word address.
- wdata0  input  DATA_WIDTH  port 0 write data.
- ack0  output  1  one-cycle completion pulse for port 0.
- rdata0  output  DATA_WIDTH  port 0 read data; valid when ack0 is high, then held.
- req1, we1, addr1, wdata1, ack1, rdata1: same roles for port 1.
- busy  output  1  high when the FSM is not in IDLE.
- grant  output  1  index of the port currently served (or last served).
- ram_address  output  ADDR_WIDTH  drives the RAM address input.
- ram_data_in  output  DATA_WIDTH  drives the RAM data_in input.
- ram_we  output  1  drives the RAM we input.
- ram_chip_select  output  1  drives the RAM chip_select input.
- ram_data_out  input  DATA_WIDTH  the RAM's combinational read output.

Behaviour:
- FSM states: IDLE, ACCESS, ACK. All outputs are registered.
- Reset (asynchronous, any time): state = IDLE; ack0 = ack1 = 0; ram_chip_select = 0; ram_we = 0; ram_address = 0; ram_data_in = 0; rdata0 = rdata1 = 0; busy = 0; grant = 0; last_served = 1 (so port 0 wins the first tie).
- Reset mid-ACCESS: chip_select and we drop immediately. The transaction is abandoned and no ack is issued. A write whose negedge had not yet occurred is lost.
- IDLE, no request: stay in IDLE; RAM outputs stay deasserted.
- IDLE, one req high: grant that port.
- IDLE, both req high: with FIXED_PRIORITY = 1, grant port 0. With FIXED_PRIORITY = 0, grant the port that is not last_served.
- IDLE -> ACCESS on a grant: at the same edge, latch the winner's addr/we/wdata into ram_address/ram_we/ram_data_in, and set ram_chip_select = 1, grant = winner, busy = 1.
- ACCESS: lasts exactly one cycle. The RAM performs any write on the negedge inside this cycle.
- ACCESS -> ACK at the next posedge:
  - if ram_we = 1, rdata is unchanged;
  - if ram_we = 0, capture ram_data_out into rdata[grant];
  - deassert ram_chip_select and ram_we;
  - set ack[grant] = 1 and last_served = grant.
- ACK -> IDLE: ack drops after exactly one cycle.
- Latency: the request is sampled at edge E0, ack is high during E1..E2, and the next grant is possible at E3. Peak throughput is one access per 3 cycles.
- Requester rules:
  - addr/we/wdata may change after the grant edge, since they are latched at grant.
  - req must be deasserted at the edge where the requester sees ack; a req still high in IDLE counts as a new request.
  - A req that rises during ACCESS/ACK waits and is evaluated in IDLE.
- rdataN holds its value until the next read completion on port N. Writes and the other port's traffic never change it.
- Round-robin guarantee: with both ports continuously requesting, grants alternate 0,1,0,1,...; no port waits more than one foreign transaction.
- Address wrap: none; the full 0..31 range is passed through unchanged.

Test Plan:
- Reset then idle 10 cycles -> ram_chip_select = 0, busy = 0, ack0 = ack1 = 0 throughout.
- Port 0 writes 32'hDEADBEEF to addr 5, then reads addr 5 -> ack0 pulses once per access, each 2 cycles after the req edge; rdata0 = 32'hDEADBEEF at the read ack.
- Both ports request simultaneously from reset (port 0 writes 32'h11 to addr 1, port 1 writes 32'h22 to addr 2), then both read their addresses -> grant order 0,1,0,1; rdata0 = 32'h11, rdata1 = 32'h22.
- FIXED_PRIORITY = 1 with req0 and req1 held high for 4 port-0 accesses -> ack1 stays 0 until req0 drops, then port 1 is served.
- Assert reset during ACCESS of a port 1 write of 32'hCAFE to addr 7 -> no ack1, chip_select drops asynchronously, FSM is in IDLE after reset release.
- Port 1 reads addr 3 (preloaded 32'h1234) while port 0 writes addr 3 with 32'h5678 -> rdata1 is 32'h1234 or 32'h5678 depending on grant order, matching round-robin; rdata0 is unchanged.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port req/ack arbiter in front of the single-port data RAM.
// Every RAM control is registered, so the RAM sees stable inputs across its negedge write.
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  grant,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic                  ram_chip_select,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t                state, state_d;
    logic                  last_served, last_served_d;
    logic                  winner;
    logic                  ack0_d, ack1_d, busy_d, grant_d;
    logic                  ram_we_d, ram_chip_select_d;
    logic [ADDR_WIDTH-1:0] ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_in_d, rdata0_d, rdata1_d;

    // A tie goes to port 0 under fixed priority, otherwise to the port not served last.
    always_comb begin
        if (req0 && req1)
            winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_served;
        else
            winner = req1;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        state_d           = state;
        last_served_d     = last_served;
        ack0_d            = 1'b0;
        ack1_d            = 1'b0;
        busy_d            = busy;
        grant_d           = grant;
        ram_we_d          = ram_we;
        ram_chip_select_d = ram_chip_select;
        ram_address_d     = ram_address;
        ram_data_in_d     = ram_data_in;
        rdata0_d          = rdata0;
        rdata1_d          = rdata1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_d           = ACCESS;
                    grant_d           = winner;
                    busy_d            = 1'b1;
                    ram_chip_select_d = 1'b1;
                    ram_we_d          = winner ? we1 : we0;
                    ram_address_d     = winner ? addr1 : addr0;
                    ram_data_in_d     = winner ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_d           = ACK;
                ram_chip_select_d = 1'b0;
                ram_we_d          = 1'b0;
                last_served_d     = grant;
                if (grant) ack1_d = 1'b1;
                else       ack0_d = 1'b1;
                if (!ram_we) begin
                    if (grant) rdata1_d = ram_data_out;
                    else       rdata0_d = ram_data_out;
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last_served     <= 1'b1;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            busy            <= 1'b0;
            grant           <= 1'b0;
            ram_we          <= 1'b0;
            ram_chip_select <= 1'b0;
            ram_address     <= '0;
            ram_data_in     <= '0;
            rdata0          <= '0;
            rdata1          <= '0;
        end else begin
            state           <= state_d;
            last_served     <= last_served_d;
            ack0            <= ack0_d;
            ack1            <= ack1_d;
            busy            <= busy_d;
            grant           <= grant_d;
            ram_we          <= ram_we_d;
            ram_chip_select <= ram_chip_select_d;
            ram_address     <= ram_address_d;
            ram_data_in     <= ram_data_in_d;
            rdata0          <= rdata0_d;
            rdata1          <= rdata1_d;
        end
    end

endmodule
